// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder with carry-in and carry-out; the shared datapath slice.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum     = total_s[3:0];
  assign cout    = total_s[4];

endmodule

// File: rtl/nibble_counter.sv
// Up-counter with synchronous clear and enable; flags the last nibble (COUNT_MAX-1) and wraps there.
module nibble_counter #(
  parameter int COUNT_MAX = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

  logic [CNT_W-1:0] count_r;

  assign tc = (count_r == CNT_W'(COUNT_MAX - 1));

  // count register: clear wins over enable, wrap after the terminal value
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en) begin
      if (tc) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_add_controller.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single adder_4bit.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;

  state_t             state_r;
  state_t             state_next_s;
  logic               load_s;
  logic               tc_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_next_s;
  logic               carry_r;
  logic               init_carry_s;
  logic [NIBBLE_W-1:0] add_a_s;
  logic [NIBBLE_W-1:0] add_b_s;
  logic [NIBBLE_W-1:0] add_sum_s;
  logic               add_cout_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_out_r;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;
  // subtract is a + ~b + 1, so the initial carry is forced high
  assign init_carry_s = op_sub ? 1'b1 : carry_in;
  assign add_b_s      = b_r[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_r}};
`else
  assign init_carry_s = carry_in;
  assign add_b_s      = b_r[NIBBLE_W-1:0];
`endif

  assign add_a_s    = a_r[NIBBLE_W-1:0];
  assign acc_next_s = (acc_r >> NIBBLE_W) | (WIDTH'(add_sum_s) << (WIDTH - NIBBLE_W));

  adder_4bit u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  nibble_counter #(
    .COUNT_MAX (NIBBLES)
  ) u_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (load_s),
    .en    (state_r == ADD),
    .tc    (tc_s)
  );

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state decode; start only matters in IDLE
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ADD;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADD: begin
        if (tc_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ADD;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // operand shift registers, carry chain and accumulator
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else if (load_s) begin
      a_r     <= a;
      b_r     <= b;
      acc_r   <= '0;
      carry_r <= init_carry_s;
`ifdef SERIAL_ADD_SUB_EN
      sub_r   <= op_sub;
`endif
    end else if (state_r == ADD) begin
      a_r     <= a_r >> NIBBLE_W;
      b_r     <= b_r >> NIBBLE_W;
      acc_r   <= acc_next_s;
      carry_r <= add_cout_s;
    end
  end

  // registered outputs; result loads only on the last ADD cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ADD);
      done_r <= (state_next_s == DONE);
      if ((state_r == ADD) && tc_s) begin
        sum_r       <= acc_next_s;
        carry_out_r <= add_cout_s;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;

endmodule
